// File: rtl/data_mem_if.sv
// Request/acknowledge bundle between the MEM-stage initiator (master) and the data-memory responder (slave).
// valid/ready contract: a req is held high with its addr/data stable until the matching one-cycle ack is seen.
interface data_mem_if;
  logic        mem_read_req;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;
  logic        mem_read_ack;
  logic        mem_write_req;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_ack;

  modport master (
    output mem_read_req, mem_read_addr,
    output mem_write_req, mem_write_addr, mem_write_data,
    input  mem_read_data, mem_read_ack, mem_write_ack
  );

  modport slave (
    input  mem_read_req, mem_read_addr,
    input  mem_write_req, mem_write_addr, mem_write_data,
    output mem_read_data, mem_read_ack, mem_write_ack
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering one level req at a time with a one-cycle ack after LATENCY cycles.
// Optional DMEM_MISALIGN_TRAP_EN adds mem_err and suppresses misaligned accesses.
module data_mem_responder #(
  parameter int LATENCY    = 3,
  parameter int ADDR_WORDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  data_mem_if.slave    bus,
  output logic         busy,
  output logic [1:0]   dbg_state
`ifdef DMEM_MISALIGN_TRAP_EN
  , output logic       mem_err
`endif
);

  localparam int         DEPTH = 1 << ADDR_WORDS;
  localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                  state, next_state;
  logic [3:0]              count, next_count;
  logic                    start, svc_req, access;
  logic                    cap_write;
  logic [ADDR_WORDS-1:0]   cap_index;
  logic [31:0]             cap_wdata;
  logic                    sel_write;
  logic [ADDR_WORDS-1:0]   sel_index;
  logic [31:0]             sel_wdata;
  logic                    bad_align;
  logic [31:0]             read_data_q;
  logic [31:0]             ram [DEPTH];

  assign start   = bus.mem_write_req | bus.mem_read_req;
  assign svc_req = cap_write ? bus.mem_write_req : bus.mem_read_req;

  // In IDLE the live inputs are used so that LATENCY=1 can access on the capture edge.
  always_comb begin
    sel_write = cap_write;
    sel_index = cap_index;
    sel_wdata = cap_wdata;
    if (state == S_IDLE) begin
      sel_write = bus.mem_write_req;
      sel_index = bus.mem_write_req ? bus.mem_write_addr[ADDR_WORDS+1:2]
                                    : bus.mem_read_addr[ADDR_WORDS+1:2];
      sel_wdata = bus.mem_write_data;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic cap_misal;
  logic sel_misal;

  always_comb begin
    sel_misal = cap_misal;
    if (state == S_IDLE) begin
      sel_misal = bus.mem_write_req ? (bus.mem_write_addr[1:0] != 2'b00)
                                    : (bus.mem_read_addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) cap_misal <= sel_misal;
  end

  assign bad_align = sel_misal;
  assign mem_err   = (state == S_ACK) && cap_misal;

  logic unused_addr;
  assign unused_addr = ^{bus.mem_write_addr[31:ADDR_WORDS+2], bus.mem_read_addr[31:ADDR_WORDS+2]};
`else
  assign bad_align = 1'b0;

  logic unused_addr;
  assign unused_addr = ^{bus.mem_write_addr[31:ADDR_WORDS+2], bus.mem_read_addr[31:ADDR_WORDS+2],
                         bus.mem_write_addr[1:0], bus.mem_read_addr[1:0]};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= 4'd0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Next-state logic; write wins when both reqs are present in IDLE.
  always_comb begin
    next_state = state;
    next_count = count;
    access     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (LATENCY == 1) begin
            next_state = S_ACK;
            access     = 1'b1;
          end else begin
            next_state = S_WAIT;
            next_count = LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!svc_req) begin
          next_state = S_IDLE;
          next_count = 4'd0;
        end else if (count == 4'd1) begin
          next_state = S_ACK;
          next_count = 4'd0;
          access     = 1'b1;
        end else begin
          next_count = count - 4'd1;
        end
      end
      S_ACK: begin
        next_state = S_RELEASE;
      end
      S_RELEASE: begin
        if (!svc_req) next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
        next_count = 4'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy              = (state != S_IDLE);
    bus.mem_read_ack  = (state == S_ACK) && !cap_write;
    bus.mem_write_ack = (state == S_ACK) && cap_write;
    bus.mem_read_data = read_data_q;
    dbg_state         = state;
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      cap_write <= sel_write;
      cap_index <= sel_index;
      cap_wdata <= sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= 32'h0;
    end else if (access && !sel_write) begin
      read_data_q <= bad_align ? 32'h0 : ram[sel_index];
    end
  end

  // RAM is deliberately not reset; a reset on the commit edge blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && access && sel_write && !bad_align) begin
      ram[sel_index] <= sel_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=3, ADDR_WORDS=10.
// Define DMEM_MISALIGN_TRAP_EN for both RTL and bench to exercise mem_err.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic [1:0] dbg_state;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic mem_err;
`endif

  int compared = 0;
  int failed   = 0;

  data_mem_if bus ();

  data_mem_responder #(.LATENCY(3), .ADDR_WORDS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .mem_err (mem_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction with minimum turnaround: req in C, ack in C+3, drop in C+4, idle in C+5.
  task automatic txn(input string tag, input bit wr, input logic [31:0] addr, input logic [31:0] data);
`ifdef DMEM_MISALIGN_TRAP_EN
    bit exp_err;
    exp_err = (addr[1:0] != 2'b00);
`endif
    if (wr) begin
      bus.mem_write_req  = 1'b1;
      bus.mem_write_addr = addr;
      bus.mem_write_data = data;
    end else begin
      bus.mem_read_req  = 1'b1;
      bus.mem_read_addr = addr;
    end
    tick();
    chk({tag, "_busy_c1"}, busy, 1);
    chk({tag, "_state_c1"}, dbg_state, 2'd1);
    chk({tag, "_ack_c1"}, {bus.mem_read_ack, bus.mem_write_ack}, 2'b00);
    bus.mem_write_addr = addr ^ 32'h40;
    bus.mem_read_addr  = addr ^ 32'h40;
    bus.mem_write_data = ~data;
    tick();
    chk({tag, "_ack_c2"}, {bus.mem_read_ack, bus.mem_write_ack}, 2'b00);
    tick();
    chk({tag, "_ack_c3"}, {bus.mem_read_ack, bus.mem_write_ack}, {!wr, wr});
    if (!wr) chk({tag, "_rdata"}, bus.mem_read_data, data);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk({tag, "_err_ack"}, mem_err, exp_err);
`endif
    tick();
    chk({tag, "_ack_c4"}, {bus.mem_read_ack, bus.mem_write_ack}, 2'b00);
    chk({tag, "_state_c4"}, dbg_state, 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk({tag, "_err_c4"}, mem_err, 1'b0);
`endif
    bus.mem_write_req = 1'b0;
    bus.mem_read_req  = 1'b0;
    tick();
    chk({tag, "_busy_c5"}, busy, 0);
    if (!wr) chk({tag, "_rdata_held"}, bus.mem_read_data, data);
  endtask

  initial begin
    bus.mem_read_req   = 1'b0;
    bus.mem_read_addr  = 32'h0;
    bus.mem_write_req  = 1'b0;
    bus.mem_write_addr = 32'h0;
    bus.mem_write_data = 32'h0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_acks", {bus.mem_read_ack, bus.mem_write_ack}, 2'b00);
    chk("rst_rdata", bus.mem_read_data, 32'h0);
    reset = 1'b0;
    tick();

    // Basic write then read-back
    txn("wr10", 1'b1, 32'h10, 32'hDEADBEEF);
    txn("rd10", 1'b0, 32'h10, 32'hDEADBEEF);

    // Simultaneous reqs: write first, read picked up after write release
    bus.mem_write_req  = 1'b1;
    bus.mem_write_addr = 32'h20;
    bus.mem_write_data = 32'h12345678;
    bus.mem_read_req   = 1'b1;
    bus.mem_read_addr  = 32'h20;
    tick(); tick(); tick();
    chk("both_c3_acks", {bus.mem_read_ack, bus.mem_write_ack}, 2'b01);
    tick();
    chk("both_c4_acks", {bus.mem_read_ack, bus.mem_write_ack}, 2'b00);
    bus.mem_write_req = 1'b0;
    tick();
    chk("both_c5_state", dbg_state, 2'd0);
    chk("both_c5_rack", bus.mem_read_ack, 1'b0);
    tick();
    chk("both_c6_busy", busy, 1);
    tick();
    chk("both_c7_acks", {bus.mem_read_ack, bus.mem_write_ack}, 2'b00);
    tick();
    chk("both_c8_acks", {bus.mem_read_ack, bus.mem_write_ack}, 2'b10);
    chk("both_rdata", bus.mem_read_data, 32'h12345678);
    tick();
    bus.mem_read_req = 1'b0;
    tick();
    chk("both_c10_busy", busy, 0);

    // Req held 5 cycles past ack gives exactly one pulse
    bus.mem_write_req  = 1'b1;
    bus.mem_write_addr = 32'h30;
    bus.mem_write_data = 32'h11112222;
    tick(); tick(); tick();
    chk("hold_ack", bus.mem_write_ack, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_noack", {bus.mem_read_ack, bus.mem_write_ack}, 2'b00);
      chk("hold_state", dbg_state, 2'd3);
    end
    bus.mem_write_req = 1'b0;
    tick();
    chk("hold_idle", busy, 0);

    // Abort in WAIT on the last wait cycle: no ack, no commit
    bus.mem_write_req  = 1'b1;
    bus.mem_write_addr = 32'h30;
    bus.mem_write_data = 32'h99999999;
    tick(); tick();
    bus.mem_write_req = 1'b0;
    tick();
    chk("abort_c3_ack", bus.mem_write_ack, 1'b0);
    chk("abort_c3_busy", busy, 0);
    tick();
    chk("abort_c4_ack", bus.mem_write_ack, 1'b0);
    txn("rd30", 1'b0, 32'h30, 32'h11112222);

    // Address wrap modulo depth
    txn("wr1000", 1'b1, 32'h1000, 32'hA5A5A5A5);
    txn("rd0000", 1'b0, 32'h0000, 32'hA5A5A5A5);

    // Reset mid-WAIT: abandoned, RAM keeps prior data
    bus.mem_write_req  = 1'b1;
    bus.mem_write_addr = 32'h10;
    bus.mem_write_data = 32'h0BADF00D;
    tick();
    reset = 1'b1;
    bus.mem_write_req = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_acks", {bus.mem_read_ack, bus.mem_write_ack}, 2'b00);
    chk("midrst_rdata", bus.mem_read_data, 32'h0);
    reset = 1'b0;
    tick(); tick();
    chk("midrst_acks2", {bus.mem_read_ack, bus.mem_write_ack}, 2'b00);
    txn("rd10_after_rst", 1'b0, 32'h10, 32'hDEADBEEF);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    txn("wr13", 1'b1, 32'h13, 32'hFFFFFFFF);
    txn("rd10_mis", 1'b0, 32'h10, 32'hDEADBEEF);
    txn("rd11", 1'b0, 32'h11, 32'h00000000);
`else
    txn("wr13", 1'b1, 32'h13, 32'hFFFFFFFF);
    txn("rd10_mis", 1'b0, 32'h10, 32'hFFFFFFFF);
    txn("rd11", 1'b0, 32'h11, 32'hFFFFFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
